dbg_prog_loader: RTL
====================

# dbg_prog_loader

Parametrised program loader between a host/debug command stream and the core's instruction-memory debug write port (`dbg_wr_en`/`dbg_addr`/`dbg_instr`). It takes a valid/ready command stream (set address, data word, run, halt), buffers data words in a small FIFO, and replays them as auto-incrementing word writes with a configurable inter-write gap. It also owns the core reset (`core_rst`): the core is held in reset while loading and released only after every buffered write has retired. It replaces hand-sequenced debug writes with a single streamed bring-up path.

## Interface
- `XLEN`, 32, data and address width.
- `FIFO_DEPTH`, 4, data-word buffer depth; power of two, ≥2.
- `IMEM_WORDS`, 64, instruction memory size in words. Legal byte addresses are 0 .. 4*IMEM_WORDS-4.
- `WR_GAP`, 0, forced idle cycles after each `dbg_wr_en` pulse; range 0..15.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted on the rising edge where `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 SET_ADDR, 01 DATA, 10 RUN, 11 HALT.
- `cmd_data` in XLEN: address for SET_ADDR, instruction word for DATA, ignored otherwise.
- `dbg_wr_en` out 1: one-cycle write strobe to instruction memory.
- `dbg_addr` out XLEN: write byte address.
- `dbg_instr` out XLEN: write data.
- `core_rst` out 1: core reset, active high.
- `running` out 1: state is RUN.
- `err` out 1: sticky error flag; cleared only by `rst`.
- `words_written` out 16: count of memory writes issued; saturates at 0xFFFF.

## Operation
- States: LOAD, DRAIN, RUN.
- **Reset values:**
  - State LOAD, write pointer `ptr` = 0, FIFO empty, gap counter = 0.
  - `dbg_wr_en`, `dbg_addr`, `dbg_instr` = 0.
  - `core_rst` = 1, `running` = 0, `err` = 0, `words_written` = 0.
- **LOAD** (`cmd_ready` = !fifo_full):
  - SET_ADDR: if `cmd_data[1:0]` = 0 and `cmd_data` < 4*IMEM_WORDS, `ptr` ← `cmd_data` and `words_written` ← 0. Otherwise set `err`; `ptr` and `words_written` are unchanged.
  - DATA: if `ptr` < 4*IMEM_WORDS, push {`ptr`, `cmd_data`} to the FIFO and `ptr` += 4. Otherwise set `err` and drop the word; the command is still accepted. `ptr` never wraps; it stops at 4*IMEM_WORDS.
  - RUN: go to DRAIN.
  - HALT: no operation.
- **DRAIN** (`cmd_ready` = 0): go to RUN when the FIFO is empty and no write strobe is pending.
- **RUN** (`cmd_ready` = 1):
  - HALT: go to LOAD.
  - SET_ADDR and DATA: accepted, set `err`, otherwise ignored.
  - RUN: no operation.
- **Write engine** (active in LOAD and DRAIN):
  - When the FIFO is non-empty and the gap counter is 0, pop one entry, drive it on `dbg_addr`/`dbg_instr`, and pulse `dbg_wr_en` for one cycle.
  - `words_written` increments on each pulse; the gap counter then loads `WR_GAP`.
  - `dbg_addr`/`dbg_instr` hold their last value between writes.
- **`core_rst`:** registered; equals (state ≠ RUN). It is never low while a FIFO entry or write strobe is outstanding.

## Timing
- **DATA latency:** DATA accepted at edge N with the FIFO empty and gap counter 0 gives `dbg_wr_en` = 1 during cycle N+1. All outputs are registered.
- **Throughput:** with a back-to-back stream, one write per (WR_GAP+1) cycles. With WR_GAP = 0, one write per cycle.
- **Push/pop:** a push and a pop in the same cycle are both performed; occupancy is unchanged.
- **RUN accepted at edge N with the FIFO empty and idle:**
  - DRAIN in cycle N+1; RUN at edge N+1.
  - `core_rst` falls and `running` rises at edge N+2.
- **HALT accepted at edge N in RUN:** `core_rst` = 1 and `running` = 0 from edge N+1. `ptr` keeps its value.
- **`rst` asserted in any state:** at the next edge all reset values are applied, and FIFO contents are discarded without being written. A strobe in flight completes only if it was already registered before that edge.

## Test plan
- **Basic load and run:** SET_ADDR 0, then DATA 0x00110193, 0x00112193, 0x00113193, then RUN (WR_GAP = 0).
  - Required: three `dbg_wr_en` pulses at addresses 0, 4, 8 with matching data.
  - Required: `words_written` = 3, then `core_rst` falls 2 cycles after RUN is accepted, and `err` = 0.
- **Gap and backpressure:** WR_GAP = 3, FIFO_DEPTH = 4, 10 DATA words streamed back to back.
  - Required: `cmd_ready` drops while the FIFO is full.
  - Required: writes are exactly 4 cycles apart, addresses step by 4, and no word is lost or duplicated.
- **Out-of-range and misaligned addresses:**
  - SET_ADDR 0x102 → `err` = 1 and `ptr` unchanged.
  - SET_ADDR 4*IMEM_WORDS-4 with DATA A, B → A is written at 0xFC; B is dropped and `err` stays 1.
- **RUN with a full FIFO:** RUN issued while 4 words are buffered.
  - Required: `cmd_ready` = 0 during DRAIN, and all 4 writes complete before `core_rst` deasserts.
- **HALT and reload:** in RUN, issue DATA (→ `err` = 1, no write), then HALT, then SET_ADDR 0x20, DATA 0x00000113, RUN.
  - Required: `core_rst` reasserts the cycle after HALT; one write at 0x20; then the core is released.
- **Reset mid-load:** `rst` asserted with 3 words buffered.
  - Required: no further `dbg_wr_en`, all outputs at reset values, and `core_rst` = 1 on the next cycle.

Source files
------------

// File: rtl/dbg_prog_loader.sv
// Streamed instruction-memory loader: buffers DATA words and replays them as
// paced auto-incrementing debug writes, holding the core in reset until drained.
module dbg_prog_loader #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int IMEM_WORDS = 64,
    parameter int WR_GAP     = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [1:0]      cmd_op_i,
    input  logic [XLEN-1:0] cmd_data_i,
    output logic            dbg_wr_en_o,
    output logic [XLEN-1:0] dbg_addr_o,
    output logic [XLEN-1:0] dbg_instr_o,
    output logic            core_rst_o,
    output logic            running_o,
    output logic            err_o,
    output logic [15:0]     words_written_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(4 * IMEM_WORDS);
    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_DATA = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_RUN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] ptr_q, ptr_d;
    logic [AW:0]     rd_q, rd_d, wr_q, wr_d;
    logic [3:0]      gap_q, gap_d;
    logic            wr_en_q, wr_en_d;
    logic [XLEN-1:0] addr_q, addr_d, instr_q, instr_d;
    logic            core_rst_q, running_q;
    logic            err_q, err_d;
    logic [15:0]     ww_q, ww_d, ww_base;
    logic [XLEN-1:0] fa_q [FIFO_DEPTH];
    logic [XLEN-1:0] fd_q [FIFO_DEPTH];

    logic empty, full;
    logic push_req, push, pop, bypass, clr_ww;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        cmd_ready_o = 1'b0;
        push_req    = 1'b0;
        clr_ww      = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                cmd_ready_o = !full;
                if (cmd_valid_i && !full) begin
                    case (cmd_op_i)
                        OP_SET: begin
                            if (cmd_data_i[1:0] == 2'b00 && cmd_data_i < MEM_BYTES) begin
                                ptr_d  = cmd_data_i;
                                clr_ww = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_DATA: begin
                            if (ptr_q < MEM_BYTES) begin
                                push_req = 1'b1;
                                ptr_d    = ptr_q + XLEN'(4);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_RUN:  state_d = S_DRAIN;
                        default: ;
                    endcase
                end
            end
            S_DRAIN: begin
                if (empty && !wr_en_q) state_d = S_RUN;
            end
            S_RUN: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_op_i == OP_HALT) state_d = S_LOAD;
                    else if (cmd_op_i != OP_RUN) err_d = 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase

        // An empty FIFO lets an incoming word go straight to the write port.
        pop     = 1'b0;
        bypass  = 1'b0;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        instr_d = instr_q;
        gap_d   = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
        if (state_q != S_RUN && gap_q == 4'd0) begin
            if (!empty) begin
                pop     = 1'b1;
                wr_en_d = 1'b1;
                addr_d  = fa_q[rd_q[AW-1:0]];
                instr_d = fd_q[rd_q[AW-1:0]];
            end else if (push_req) begin
                bypass  = 1'b1;
                wr_en_d = 1'b1;
                addr_d  = ptr_q;
                instr_d = cmd_data_i;
            end
        end
        if (wr_en_d) gap_d = 4'(WR_GAP);
        push = push_req && !bypass;
        rd_d = pop  ? rd_q + (AW+1)'(1) : rd_q;
        wr_d = push ? wr_q + (AW+1)'(1) : wr_q;

        ww_base = clr_ww ? 16'd0 : ww_q;
        ww_d    = (wr_en_d && ww_base != 16'hFFFF) ? ww_base + 16'd1 : ww_base;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_LOAD;
            ptr_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            gap_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            err_q      <= 1'b0;
            ww_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            gap_q      <= gap_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            core_rst_q <= (state_q != S_RUN);
            running_q  <= (state_q == S_RUN);
            err_q      <= err_d;
            ww_q       <= ww_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fa_q[wr_q[AW-1:0]] <= ptr_q;
            fd_q[wr_q[AW-1:0]] <= cmd_data_i;
        end
    end

    assign dbg_wr_en_o     = wr_en_q;
    assign dbg_addr_o      = addr_q;
    assign dbg_instr_o     = instr_q;
    assign core_rst_o      = core_rst_q;
    assign running_o       = running_q;
    assign err_o           = err_q;
    assign words_written_o = ww_q;
endmodule
